// File: rtl/butterfly_4_pipe.sv
// Pipelined radix-4 DIT butterfly with twiddles on b, c, d, valid/ready flow control,
// per-beat inverse/scale modes and output saturation. Latency is 4 edges after acceptance.
module butterfly_4_pipe #(
    parameter int WIDTH    = 24,
    parameter int TW_WIDTH = 13,
    parameter int TW_FRAC  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  inv,
    input  logic                  scale,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [WIDTH-1:0]      c,
    input  logic [WIDTH-1:0]      d,
    input  logic [2*TW_WIDTH-1:0] w1,
    input  logic [2*TW_WIDTH-1:0] w2,
    input  logic [2*TW_WIDTH-1:0] w3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out0,
    output logic [WIDTH-1:0]      out1,
    output logic [WIDTH-1:0]      out2,
    output logic [WIDTH-1:0]      out3,
    output logic                  ovf
);

    localparam int HALF    = WIDTH / 2;
    localparam int PW      = HALF + TW_WIDTH + 1;
    localparam int SW      = HALF + 5;
    localparam int SAT_LIM = 2 ** (HALF - 1);

    localparam logic signed [PW-1:0] RND     = PW'(2 ** (TW_FRAC - 1));
    localparam logic signed [SW-1:0] SAT_MAX = SW'(SAT_LIM - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-SAT_LIM);

    logic w_stall;
    logic w_adv;

    // The whole pipe freezes as one unit while the output beat is refused.
    assign w_stall  = out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    // ---------------- S1: input registers ----------------
    logic                  r_s1_valid;
    logic                  r_s1_inv;
    logic                  r_s1_scale;
    logic [WIDTH-1:0]      r_s1_a;
    logic [WIDTH-1:0]      r_s1_x [3];
    logic [2*TW_WIDTH-1:0] r_s1_w [3];
    logic [WIDTH-1:0]      w_x_in [3];
    logic [2*TW_WIDTH-1:0] w_w_in [3];

    assign w_x_in[0] = b;
    assign w_x_in[1] = c;
    assign w_x_in[2] = d;
    assign w_w_in[0] = w1;
    assign w_w_in[1] = w2;
    assign w_w_in[2] = w3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_a     <= a;
            r_s1_inv   <= inv;
            r_s1_scale <= scale;
            for (int k = 0; k < 3; k++) begin
                r_s1_x[k] <= w_x_in[k];
                r_s1_w[k] <= w_w_in[k];
            end
        end
    end

    // ---------------- S2: full-precision complex multiplies ----------------
    logic signed [PW-1:0] w_prod_re [3];
    logic signed [PW-1:0] w_prod_im [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_mul
        logic signed [PW-1:0] w_xr, w_xi, w_tr, w_ti;
        assign w_xr = PW'($signed(r_s1_x[gi][WIDTH-1:HALF]));
        assign w_xi = PW'($signed(r_s1_x[gi][HALF-1:0]));
        assign w_tr = PW'($signed(r_s1_w[gi][2*TW_WIDTH-1:TW_WIDTH]));
        assign w_ti = PW'($signed(r_s1_w[gi][TW_WIDTH-1:0]));
        assign w_prod_re[gi] = w_xr * w_tr - w_xi * w_ti;
        assign w_prod_im[gi] = w_xr * w_ti + w_xi * w_tr;
    end

    logic                 r_s2_valid;
    logic                 r_s2_inv;
    logic                 r_s2_scale;
    logic [WIDTH-1:0]     r_s2_a;
    logic signed [PW-1:0] r_s2_re [3];
    logic signed [PW-1:0] r_s2_im [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s2_a     <= r_s1_a;
            r_s2_inv   <= r_s1_inv;
            r_s2_scale <= r_s1_scale;
            for (int k = 0; k < 3; k++) begin
                r_s2_re[k] <= w_prod_re[k];
                r_s2_im[k] <= w_prod_im[k];
            end
        end
    end

    // ---------------- S3: round twiddled values, form the butterfly ----------------
    logic signed [SW-1:0] w_tw_re [3];
    logic signed [SW-1:0] w_tw_im [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        logic signed [PW-1:0] w_rnd_re, w_rnd_im;
        assign w_rnd_re    = (r_s2_re[gi] + RND) >>> TW_FRAC;
        assign w_rnd_im    = (r_s2_im[gi] + RND) >>> TW_FRAC;
        assign w_tw_re[gi] = SW'(w_rnd_re);
        assign w_tw_im[gi] = SW'(w_rnd_im);
    end

    logic signed [SW-1:0] w_ar, w_ai;
    logic signed [SW-1:0] w_fwd1_re, w_fwd1_im, w_fwd3_re, w_fwd3_im;
    logic signed [SW-1:0] w_bf_re [4];
    logic signed [SW-1:0] w_bf_im [4];

    assign w_ar = SW'($signed(r_s2_a[WIDTH-1:HALF]));
    assign w_ai = SW'($signed(r_s2_a[HALF-1:0]));

    // -j*(x+jy) = y - jx and +j*(x+jy) = -y + jx: only swaps and sign flips.
    assign w_fwd1_re = w_ar + w_tw_im[0] - w_tw_re[1] - w_tw_im[2];
    assign w_fwd1_im = w_ai - w_tw_re[0] - w_tw_im[1] + w_tw_re[2];
    assign w_fwd3_re = w_ar - w_tw_im[0] - w_tw_re[1] + w_tw_im[2];
    assign w_fwd3_im = w_ai + w_tw_re[0] - w_tw_im[1] - w_tw_re[2];

    assign w_bf_re[0] = w_ar + w_tw_re[0] + w_tw_re[1] + w_tw_re[2];
    assign w_bf_im[0] = w_ai + w_tw_im[0] + w_tw_im[1] + w_tw_im[2];
    assign w_bf_re[2] = w_ar - w_tw_re[0] + w_tw_re[1] - w_tw_re[2];
    assign w_bf_im[2] = w_ai - w_tw_im[0] + w_tw_im[1] - w_tw_im[2];
    assign w_bf_re[1] = r_s2_inv ? w_fwd3_re : w_fwd1_re;
    assign w_bf_im[1] = r_s2_inv ? w_fwd3_im : w_fwd1_im;
    assign w_bf_re[3] = r_s2_inv ? w_fwd1_re : w_fwd3_re;
    assign w_bf_im[3] = r_s2_inv ? w_fwd1_im : w_fwd3_im;

    logic                 r_s3_valid;
    logic                 r_s3_scale;
    logic signed [SW-1:0] r_s3_re [4];
    logic signed [SW-1:0] r_s3_im [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s3_scale <= r_s2_scale;
            for (int k = 0; k < 4; k++) begin
                r_s3_re[k] <= w_bf_re[k];
                r_s3_im[k] <= w_bf_im[k];
            end
        end
    end

    // ---------------- S4: optional /4 with rounding, then saturate to outputs ----------------
    logic signed [SW-1:0] w_sc_re [4];
    logic signed [SW-1:0] w_sc_im [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_scale
        assign w_sc_re[gi] = r_s3_scale ? (r_s3_re[gi] + SW'(2)) >>> 2 : r_s3_re[gi];
        assign w_sc_im[gi] = r_s3_scale ? (r_s3_im[gi] + SW'(2)) >>> 2 : r_s3_im[gi];
    end

    logic                 r_s4_valid;
    logic signed [SW-1:0] r_s4_re [4];
    logic signed [SW-1:0] r_s4_im [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s4_valid <= 1'b0;
        end else if (w_adv) begin
            r_s4_valid <= r_s3_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < 4; k++) begin
                r_s4_re[k] <= w_sc_re[k];
                r_s4_im[k] <= w_sc_im[k];
            end
        end
    end

    logic [WIDTH-1:0] w_out [4];
    logic [3:0]       w_sat_vec;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sat
        logic            w_hi_re, w_lo_re, w_hi_im, w_lo_im;
        logic [HALF-1:0] w_sat_re, w_sat_im;
        assign w_hi_re  = r_s4_re[gi] > SAT_MAX;
        assign w_lo_re  = r_s4_re[gi] < SAT_MIN;
        assign w_hi_im  = r_s4_im[gi] > SAT_MAX;
        assign w_lo_im  = r_s4_im[gi] < SAT_MIN;
        assign w_sat_re = w_hi_re ? SAT_MAX[HALF-1:0] :
                          w_lo_re ? SAT_MIN[HALF-1:0] : r_s4_re[gi][HALF-1:0];
        assign w_sat_im = w_hi_im ? SAT_MAX[HALF-1:0] :
                          w_lo_im ? SAT_MIN[HALF-1:0] : r_s4_im[gi][HALF-1:0];
        assign w_out[gi]     = {w_sat_re, w_sat_im};
        assign w_sat_vec[gi] = w_hi_re | w_lo_re | w_hi_im | w_lo_im;
    end

    logic             r_out_valid;
    logic             r_ovf;
    logic [WIDTH-1:0] r_out [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_out[k] <= '0;
            end
        end else if (w_adv) begin
            r_out_valid <= r_s4_valid;
            r_ovf       <= r_s4_valid & (|w_sat_vec);
            for (int k = 0; k < 4; k++) begin
                r_out[k] <= w_out[k];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign out0      = r_out[0];
    assign out1      = r_out[1];
    assign out2      = r_out[2];
    assign out3      = r_out[3];

endmodule

// File: tb/tb_butterfly_4_pipe.sv
// Bench for butterfly_4_pipe: directed spec cases, stall/reset scenarios and random
// traffic scored against an integer-arithmetic reference of the radix-4 butterfly.
module tb_butterfly_4_pipe;

    localparam int WIDTH = 24;
    localparam int TW    = 13;
    localparam int HALF  = WIDTH / 2;

    localparam logic [2*TW-1:0] W_ONE   = {13'h0800, 13'h0000};
    localparam logic [2*TW-1:0] W_NEG_J = {13'h0000, 13'h1800};

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, inv, scale;
    logic [WIDTH-1:0]  a, b, c, d;
    logic [2*TW-1:0]   w1, w2, w3;
    logic              out_valid, out_ready, ovf;
    logic [WIDTH-1:0]  out0, out1, out2, out3;

    always #5 clk = ~clk;

    butterfly_4_pipe #(.WIDTH(WIDTH), .TW_WIDTH(TW), .TW_FRAC(11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inv(inv), .scale(scale), .a(a), .b(b), .c(c), .d(d),
        .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .ovf(ovf)
    );

    typedef struct packed {
        logic [3:0][WIDTH-1:0] o;
        logic                  ovf;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pk(input int re, input int im);
        logic [HALF-1:0] r, i;
        r = re[HALF-1:0];
        i = im[HALF-1:0];
        return {r, i};
    endfunction

    // Reference: twiddle, radix-4 kernel with sign s = +1 (inverse) / -1 (forward), scale, clamp.
    function automatic exp_t model(input logic [WIDTH-1:0] xa, xb, xc, xd,
                                   input logic [2*TW-1:0] t1, t2, t3, input logic iv, sc);
        logic [WIDTH-1:0] xs [4];
        logic [2*TW-1:0]  ts [3];
        int xr [4], xi [4], vr [4], vi [4], comp [8];
        int wr, wi, pr, pim, sg;
        exp_t m;
        xs = '{xa, xb, xc, xd};
        ts = '{t1, t2, t3};
        for (int k = 0; k < 4; k++) begin
            xr[k] = int'($signed(xs[k][WIDTH-1:HALF]));
            xi[k] = int'($signed(xs[k][HALF-1:0]));
        end
        for (int k = 1; k < 4; k++) begin
            wr    = int'($signed(ts[k-1][2*TW-1:TW]));
            wi    = int'($signed(ts[k-1][TW-1:0]));
            pr    = xr[k] * wr - xi[k] * wi;
            pim   = xr[k] * wi + xi[k] * wr;
            xr[k] = (pr + 1024) >>> 11;
            xi[k] = (pim + 1024) >>> 11;
        end
        sg = iv ? 1 : -1;
        vr[0] = xr[0] + xr[1] + xr[2] + xr[3];
        vi[0] = xi[0] + xi[1] + xi[2] + xi[3];
        vr[2] = xr[0] - xr[1] + xr[2] - xr[3];
        vi[2] = xi[0] - xi[1] + xi[2] - xi[3];
        vr[1] = xr[0] - sg * xi[1] - xr[2] + sg * xi[3];
        vi[1] = xi[0] + sg * xr[1] - xi[2] - sg * xr[3];
        vr[3] = xr[0] + sg * xi[1] - xr[2] - sg * xi[3];
        vi[3] = xi[0] - sg * xr[1] - xi[2] + sg * xr[3];
        m.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            comp[2*k]   = vr[k];
            comp[2*k+1] = vi[k];
        end
        for (int k = 0; k < 8; k++) begin
            if (sc) comp[k] = (comp[k] + 2) >>> 2;
            if (comp[k] > 2047) begin comp[k] = 2047;  m.ovf = 1'b1; end
            if (comp[k] < -2048) begin comp[k] = -2048; m.ovf = 1'b1; end
        end
        for (int k = 0; k < 4; k++) m.o[k] = pk(comp[2*k], comp[2*k+1]);
        return m;
    endfunction

    task automatic send(input logic [WIDTH-1:0] xa, xb, xc, xd,
                        input logic [2*TW-1:0] t1, t2, t3, input logic iv, sc);
        @(negedge clk);
        a = xa; b = xb; c = xc; d = xd;
        w1 = t1; w2 = t2; w3 = t3;
        inv = iv; scale = sc; in_valid = 1'b1;
        for (int t = 0; t < 200 && !in_ready; t++) @(negedge clk);
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        exp_q.push_back(model(xa, xb, xc, xd, t1, t2, t3, iv, sc));
        #1 in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] xa, xb, xc, xd,
                            input logic [2*TW-1:0] t1, input logic iv, sc,
                            input logic [WIDTH-1:0] e0, e1, e2, e3, input logic eo);
        send(xa, xb, xc, xd, t1, W_ONE, W_ONE, iv, sc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({tag, "_lat"}, out_valid, (k == 4));
        end
        chk({tag, "_out0"}, out0, e0);
        chk({tag, "_out1"}, out1, e1);
        chk({tag, "_out2"}, out2, e2);
        chk({tag, "_out3"}, out3, e3);
        chk({tag, "_ovf"}, ovf, eo);
        @(posedge clk);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Scoreboard: order/data on delivery, held outputs and in_ready while stalled.
    logic [WIDTH-1:0] prev_o [4];
    logic             prev_ovf;
    bit               prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out0", out0, prev_o[0]);
                chk("hold_out1", out1, prev_o[1]);
                chk("hold_out2", out2, prev_o[2]);
                chk("hold_out3", out3, prev_o[3]);
                chk("hold_ovf", ovf, prev_ovf);
            end
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_out0", out0, e.o[0]);
                    chk("sb_out1", out1, e.o[1]);
                    chk("sb_out2", out2, e.o[2]);
                    chk("sb_out3", out3, e.o[3]);
                    chk("sb_ovf", ovf, e.ovf);
                    $display("beat out0=%h out1=%h out2=%h out3=%h ovf=%0d", out0, out1, out2, out3, ovf);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o[0] = out0; prev_o[1] = out1; prev_o[2] = out2; prev_o[3] = out3;
            prev_ovf = ovf;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    bit done_send;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inv = 1'b0; scale = 1'b0;
        a = '0; b = '0; c = '0; d = '0; w1 = '0; w2 = '0; w3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_out3", out3, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        directed("fwd", pk(100, 0), pk(150, 0), pk(200, 0), pk(250, 0), W_ONE, 1'b0, 1'b0,
                 pk(700, 0), pk(-100, 100), pk(-100, 0), pk(-100, -100), 1'b0);
        directed("inv", pk(100, 0), pk(150, 0), pk(200, 0), pk(250, 0), W_ONE, 1'b1, 1'b0,
                 pk(700, 0), pk(-100, -100), pk(-100, 0), pk(-100, 100), 1'b0);
        directed("scale", pk(100, 0), pk(150, 0), pk(200, 0), pk(250, 0), W_ONE, 1'b0, 1'b1,
                 pk(175, 0), pk(-25, 25), pk(-25, 0), pk(-25, -25), 1'b0);
        directed("negj", pk(100, 0), pk(150, 0), pk(0, 0), pk(0, 0), W_NEG_J, 1'b0, 1'b0,
                 pk(100, -150), pk(-50, 0), pk(100, 150), pk(250, 0), 1'b0);
        directed("sat", pk(2000, 0), pk(2000, 0), pk(2000, 0), pk(2000, 0), W_ONE, 1'b0, 1'b0,
                 pk(2047, 0), pk(0, 0), pk(0, 0), pk(0, 0), 1'b1);

        // Six distinct beats with a three-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(pk(i * 37 + 5, -i * 11), pk(i * 3, 7), pk(-i * 20, i), pk(9, -i * 5),
                         W_ONE, W_NEG_J, W_ONE, i[0], 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("stall");

        // Random traffic with random downstream backpressure.
        done_send = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [2*TW-1:0] r1, r2, r3;
                    r1 = (i % 3 == 0) ? W_ONE : 26'($urandom);
                    r2 = 26'($urandom);
                    r3 = (i % 4 == 0) ? W_NEG_J : 26'($urandom);
                    send(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom),
                         r1, r2, r3, 1'($urandom), 1'($urandom));
                end
                done_send = 1'b1;
            end
            begin
                while (!done_send) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("rand");

        // Reset with three beats in flight: none of them may emerge.
        for (int i = 0; i < 3; i++)
            send(pk(300 + i, 1), pk(40, -i), pk(5, 5), pk(-7, 2), W_ONE, W_ONE, W_ONE, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_beat", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
